// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: FSM state encoding and default operand width.
package arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int ARITH_W_DEFAULT = 4;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bout set when the bit underflows.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_rb_subtractor.sv
// Bit-serial ripple-borrow subtractor: D = X - Y - Bin, one bit per clock, LSB
// first, with the borrow leaving every bit position kept in b.
module serial_rb_subtractor
  import arith_pkg::*;
#(
  parameter int W = ARITH_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] d,
  output logic [W-1:0] b,
  output logic         bout
);

  // Index counter only needs to reach W-1; the run ends there so it never wraps.
  localparam int IW = (W > 1) ? $clog2(W) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);

  state_e         state_q;
  logic [IW-1:0]  idx_q;
  logic           br_q;
  logic [W-1:0]   x_q;
  logic [W-1:0]   y_q;
  logic [W-1:0]   d_q;
  logic [W-1:0]   b_q;
  logic           bout_q;
  logic           busy_q;
  logic           done_q;

  logic           fs_d;
  logic           fs_bout;
  logic [W-1:0]   d_d;
  logic [W-1:0]   b_d;

  // Single subtractor cell, steered to the active bit by the index.
  full_subtractor u_fs (
    .a    (x_q[idx_q]),
    .b    (y_q[idx_q]),
    .bin  (br_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // Result vectors with the active bit replaced by this cycle's cell outputs.
  always_comb begin
    d_d        = d_q;
    b_d        = b_q;
    d_d[idx_q] = fs_d;
    b_d[idx_q] = fs_bout;
  end

  // Control FSM with operand, borrow and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      br_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      d_q     <= '0;
      b_q     <= '0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            x_q     <= x;
            y_q     <= y;
            br_q    <= bin;
            d_q     <= '0;
            b_q     <= '0;
            bout_q  <= 1'b0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          d_q  <= d_d;
          b_q  <= b_d;
          br_q <= fs_bout;
          if (idx_q == LAST_IDX) begin
            bout_q  <= fs_bout;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign d    = d_q;
  assign b    = b_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_rb_subtractor.sv
// Self-checking bench for serial_rb_subtractor (W=4).
module tb_serial_rb_subtractor;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] d;
    logic [W-1:0] b;
    logic         bout;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic         bin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic [W-1:0] b;
  logic         bout;

  int tests = 0;
  int fails = 0;
  int done_seen = 0;
  int ops = 0;
  exp_t expq[$];

  always #5 clk = ~clk;

  serial_rb_subtractor #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .x     (x),
    .y     (y),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .b     (b),
    .bout  (bout)
  );

  // Reference: plain integer subtraction; the borrow out of bit i is whether
  // the low (i+1) bits of x are smaller than those of y plus the borrow-in.
  function automatic exp_t model(int xv, int yv, int bv);
    exp_t e;
    int   diff;
    int   m;
    diff = xv - yv - bv;
    e.d  = W'(diff & ((1 << W) - 1));
    for (int i = 0; i < W; i++) begin
      m = 1 << (i + 1);
      e.b[i] = ((xv % m) < ((yv % m) + bv));
    end
    e.bout = (xv < (yv + bv));
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Compare process: every done pulse must match the oldest accepted operation.
  always @(negedge clk) begin
    exp_t e;
    chk("busy_done_exclusive", {31'd0, busy & done}, 32'd0);
    if (done) begin
      done_seen++;
      if (expq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_done: got done=1, expected no pending operation at %0t", $time);
      end else begin
        e = expq.pop_front();
        chk("d", {28'd0, d}, {28'd0, e.d});
        chk("b", {28'd0, b}, {28'd0, e.b});
        chk("bout", {31'd0, bout}, {31'd0, e.bout});
      end
    end
  end

  // Drive one operation starting now; return in the DONE cycle (or after
  // gap idle cycles). glitch re-pulses start with new operands during RUN.
  task automatic run_op(input int xv, input int yv, input int bv, input bit glitch, input int gap);
    exp_t e;
    int   k;
    bit   got;
    e = model(xv, yv, bv);
    x = W'(xv);
    y = W'(yv);
    bin = bv[0];
    start = 1'b1;
    expq.push_back(e);
    ops++;
    @(posedge clk); #1;
    start = 1'b0;
    x = W'($urandom);
    y = W'($urandom);
    bin = 1'($urandom);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    k = 0;
    got = 1'b0;
    while (k < W + 4 && !got) begin
      if (glitch && k == 1) begin
        start = 1'b1;
        x = ~W'(xv);
        y = W'(xv);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      k++;
      if (done) got = 1'b1;
    end
    start = 1'b0;
    chk("latency", k, W);
    chk("busy_at_done", {31'd0, busy}, 32'd0);
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
      chk("hold_d", {28'd0, d}, {28'd0, e.d});
      chk("hold_bout", {31'd0, bout}, {31'd0, e.bout});
      chk("idle_done_low", {31'd0, done}, 32'd0);
    end
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_d", {28'd0, d}, 32'd0);
    chk("rst_b", {28'd0, b}, 32'd0);
    chk("rst_bout", {31'd0, bout}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Hand-computed cases
    run_op(9, 3, 0, 1'b0, 0);
    chk("lit_9_3_d", {28'd0, d}, 32'h6);
    chk("lit_9_3_b", {28'd0, b}, 32'h6);
    chk("lit_9_3_bout", {31'd0, bout}, 32'd0);
    run_op(3, 9, 0, 1'b0, 1);
    chk("lit_3_9_d", {28'd0, d}, 32'hA);
    chk("lit_3_9_b", {28'd0, b}, 32'h8);
    chk("lit_3_9_bout", {31'd0, bout}, 32'd1);
    run_op(0, 0, 1, 1'b0, 0);
    chk("lit_0_0_1_d", {28'd0, d}, 32'hF);
    chk("lit_0_0_1_b", {28'd0, b}, 32'hF);
    chk("lit_0_0_1_bout", {31'd0, bout}, 32'd1);

    // Exhaustive, back-to-back (start driven in each DONE cycle)
    for (int bv = 0; bv < 2; bv++)
      for (int xv = 0; xv < 16; xv++)
        for (int yv = 0; yv < 16; yv++)
          run_op(xv, yv, bv, 1'b0, 0);

    // Start re-pulsed with different operands during RUN
    run_op(12, 5, 1, 1'b1, 2);
    chk("glitch_d", {28'd0, d}, 32'h6);

    // Randomized operations with random idle gaps
    for (int n = 0; n < 60; n++)
      run_op(int'($urandom_range(15)), int'($urandom_range(15)),
             int'($urandom_range(1)), 1'($urandom), int'($urandom_range(2)));

    // Reset pulled low while bit 2 is being processed
    @(posedge clk); #1;
    x = 4'd5;
    y = 4'd10;
    bin = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_d", {28'd0, d}, 32'd0);
    chk("midrst_b", {28'd0, b}, 32'd0);
    chk("midrst_bout", {31'd0, bout}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(7, 13, 1, 1'b0, 1);
    chk("post_rst_d", {28'd0, d}, 32'h9);
    chk("post_rst_bout", {31'd0, bout}, 32'd1);

    repeat (3) @(posedge clk);
    #1;
    chk("done_count", done_seen, ops);
    chk("queue_drained", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
